// File: rtl/rv32i_types.sv
// Shared types for the memory-side of the rv32i core.
// Holds the physical-memory scheduler state encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_SERVE_D = 2'd1,
        PS_SERVE_I = 2'd2,
        PS_SERVE_P = 2'd3
    } pmem_sched_state_t;

endpackage

// File: rtl/pmem_scheduler.sv
// Three-way arbiter (dcache, icache, next-line prefetch) in front of the cacheline adaptor.
// One transaction outstanding; dcache first, with an icache anti-starvation override.
module pmem_scheduler
    import rv32i_types::*;
#(
    parameter int s_offset     = 5,
    parameter int starve_limit = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        i_pmem_read,
    input  logic [31:0]                 i_pmem_address,
    output logic [(2**s_offset)*8-1:0]  i_pmem_rdata,
    output logic                        i_pmem_resp,

    input  logic                        d_pmem_read,
    input  logic                        d_pmem_write,
    input  logic [31:0]                 d_pmem_address,
    input  logic [(2**s_offset)*8-1:0]  d_pmem_wdata,
    output logic [(2**s_offset)*8-1:0]  d_pmem_rdata,
    output logic                        d_pmem_resp,

    input  logic                        p_pmem_read,
    input  logic [31:0]                 p_pmem_address,
    output logic [(2**s_offset)*8-1:0]  p_pmem_rdata,
    output logic                        p_pmem_resp,

    output logic                        pmem_read_c,
    output logic                        pmem_write_c,
    output logic [31:0]                 pmem_address_c,
    output logic [(2**s_offset)*8-1:0]  pmem_wdata_c,
    input  logic [(2**s_offset)*8-1:0]  pmem_rdata_c,
    input  logic                        pmem_resp_c
);

    localparam int LW = (2**s_offset)*8;
    localparam int SW = $clog2(starve_limit + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(starve_limit);

    pmem_sched_state_t state_q, state_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [LW-1:0]     wdata_q, wdata_d;
    logic [LW-1:0]     i_rdata_q, i_rdata_d;
    logic [LW-1:0]     d_rdata_q, d_rdata_d;
    logic [LW-1:0]     p_rdata_q, p_rdata_d;
    logic              d_req, starved;

    assign d_req   = d_pmem_read | d_pmem_write;
    assign starved = i_pmem_read && (starve_cnt_q == STARVE_MAX);

    // Responses only count in a serve state; a stray adaptor resp in IDLE is dropped.
    assign i_pmem_resp = (state_q == PS_SERVE_I) && pmem_resp_c;
    assign d_pmem_resp = (state_q == PS_SERVE_D) && pmem_resp_c;
    assign p_pmem_resp = (state_q == PS_SERVE_P) && pmem_resp_c;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        read_d       = read_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_pmem_resp ? pmem_rdata_c : i_rdata_q;
        d_rdata_d    = d_pmem_resp ? pmem_rdata_c : d_rdata_q;
        p_rdata_d    = p_pmem_resp ? pmem_rdata_c : p_rdata_q;

        case (state_q)
            PS_IDLE: begin
                if (!i_pmem_read) starve_cnt_d = '0;
                if (d_req && !starved) begin
                    // Write wins over a simultaneous read; the read is re-granted later.
                    state_d = PS_SERVE_D;
                    addr_d  = d_pmem_address;
                    wdata_d = d_pmem_wdata;
                    write_d = d_pmem_write;
                    read_d  = !d_pmem_write;
                    if (i_pmem_read && (starve_cnt_q != STARVE_MAX))
                        starve_cnt_d = starve_cnt_q + SW'(1);
                end else if (i_pmem_read) begin
                    state_d      = PS_SERVE_I;
                    addr_d       = i_pmem_address;
                    wdata_d      = '0;
                    write_d      = 1'b0;
                    read_d       = 1'b1;
                    starve_cnt_d = '0;
                end else if (p_pmem_read) begin
                    state_d = PS_SERVE_P;
                    addr_d  = p_pmem_address;
                    wdata_d = '0;
                    write_d = 1'b0;
                    read_d  = 1'b1;
                end
            end
            default: begin
                if (pmem_resp_c) begin
                    state_d = PS_IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PS_IDLE;
            starve_cnt_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            p_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            p_rdata_q    <= p_rdata_d;
        end
    end

    assign pmem_read_c    = read_q;
    assign pmem_write_c   = write_q;
    assign pmem_address_c = addr_q;
    assign pmem_wdata_c   = wdata_q;
    // Granted requester sees the adaptor data in the resp cycle; others hold.
    assign i_pmem_rdata   = i_rdata_d;
    assign d_pmem_rdata   = d_rdata_d;
    assign p_pmem_rdata   = p_rdata_d;

endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed bench for pmem_scheduler: priority, starvation, prefetch, reset abandonment.
module tb_pmem_scheduler;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read, d_pmem_read, d_pmem_write, p_pmem_read;
    logic [31:0]   i_pmem_address, d_pmem_address, p_pmem_address;
    logic [LW-1:0] d_pmem_wdata, pmem_rdata_c;
    logic          pmem_resp_c;
    logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, p_pmem_rdata, pmem_wdata_c;
    logic          i_pmem_resp, d_pmem_resp, p_pmem_resp;
    logic          pmem_read_c, pmem_write_c;
    logic [31:0]   pmem_address_c;

    int checks = 0;
    int errors = 0;

    pmem_scheduler #(.s_offset(5), .starve_limit(4)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .p_pmem_read(p_pmem_read), .p_pmem_address(p_pmem_address),
        .p_pmem_rdata(p_pmem_rdata), .p_pmem_resp(p_pmem_resp),
        .pmem_read_c(pmem_read_c), .pmem_write_c(pmem_write_c),
        .pmem_address_c(pmem_address_c), .pmem_wdata_c(pmem_wdata_c),
        .pmem_rdata_c(pmem_rdata_c), .pmem_resp_c(pmem_resp_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Raise adaptor resp with data for the current cycle and let combinational outputs settle.
    task automatic resp_on(input logic [LW-1:0] data);
        pmem_rdata_c = data;
        pmem_resp_c  = 1'b1;
        #1;
    endtask

    logic [LW-1:0] dat_a, dat_b, dat_c, dat_d, dat_e, dat_f, wdat;

    initial begin
        dat_a = {8{32'hA5A5_0001}};
        dat_b = {8{32'hB0B0_0002}};
        dat_c = {8{32'hC3C3_0003}};
        dat_d = {8{32'hD4D4_0004}};
        dat_e = {8{32'hE5E5_0005}};
        dat_f = {8{32'hF6F6_0006}};
        wdat  = {8{32'h1234_5678}};

        rst = 1'b1;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; p_pmem_read = 0;
        i_pmem_address = '0; d_pmem_address = '0; p_pmem_address = '0;
        d_pmem_wdata = '0; pmem_rdata_c = '0; pmem_resp_c = 0;
        cyc(); cyc();

        // Reset state
        chk("rst_read_c", LW'(pmem_read_c), '0);
        chk("rst_write_c", LW'(pmem_write_c), '0);
        chk("rst_addr_c", LW'(pmem_address_c), '0);
        chk("rst_wdata_c", pmem_wdata_c, '0);
        chk("rst_resps", LW'({i_pmem_resp, d_pmem_resp, p_pmem_resp}), '0);
        chk("rst_i_rdata", i_pmem_rdata, '0);
        chk("rst_d_rdata", d_pmem_rdata, '0);
        chk("rst_p_rdata", p_pmem_rdata, '0);

        // Single icache read; first grant on first edge after reset release
        rst = 1'b0;
        i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("i1_read_c_cyc%0d", k), LW'(pmem_read_c), LW'(1));
            chk($sformatf("i1_resp_idle_cyc%0d", k), LW'(i_pmem_resp), '0);
        end
        chk("i1_addr", LW'(pmem_address_c), LW'(32'h0000_1000));
        cyc();
        chk("i1_read_c_cyc6", LW'(pmem_read_c), LW'(1));
        resp_on(dat_a);
        chk("i1_resp", LW'(i_pmem_resp), LW'(1));
        chk("i1_rdata", i_pmem_rdata, dat_a);
        chk("i1_other_resp", LW'({d_pmem_resp, p_pmem_resp}), '0);
        chk("i1_d_rdata_hold", d_pmem_rdata, '0);
        i_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;
        chk("i1_bubble_read_c", LW'(pmem_read_c), '0);
        chk("i1_resp_once", LW'(i_pmem_resp), '0);
        chk("i1_rdata_hold", i_pmem_rdata, dat_a);

        // Stray adaptor resp in IDLE is ignored
        resp_on(dat_f);
        chk("idle_resp_ignored", LW'({i_pmem_resp, d_pmem_resp, p_pmem_resp}), '0);
        chk("idle_rdata_hold", i_pmem_rdata, dat_a);
        cyc();
        pmem_resp_c = 0;
        chk("idle_resp_no_cmd", LW'({pmem_read_c, pmem_write_c}), '0);

        // Simultaneous d write and i read: write first, i after one bubble
        d_pmem_write = 1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = wdat;
        i_pmem_read = 1; i_pmem_address = 32'h0000_2000;
        cyc();
        chk("dw_write_c", LW'({pmem_read_c, pmem_write_c}), LW'(2'b01));
        chk("dw_addr", LW'(pmem_address_c), LW'(32'h8000_0040));
        chk("dw_wdata", pmem_wdata_c, wdat);
        d_pmem_wdata = '0;  // latched copy must not follow
        resp_on(dat_f);
        chk("dw_resp", LW'({d_pmem_resp, i_pmem_resp}), LW'(2'b10));
        chk("dw_wdata_latched", pmem_wdata_c, wdat);
        d_pmem_write = 0;
        cyc();
        pmem_resp_c = 0;
        chk("dw_bubble", LW'({pmem_read_c, pmem_write_c}), '0);
        cyc();
        chk("dw_i_read_c", LW'({pmem_read_c, pmem_write_c}), LW'(2'b10));
        chk("dw_i_addr", LW'(pmem_address_c), LW'(32'h0000_2000));
        resp_on(dat_b);
        chk("dw_i_resp", LW'(i_pmem_resp), LW'(1));
        chk("dw_i_rdata", i_pmem_rdata, dat_b);
        i_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;

        // Starvation: d back-to-back with i held -> D,D,D,D,I,D
        d_pmem_read = 1; d_pmem_address = 32'h0000_4000;
        i_pmem_read = 1; i_pmem_address = 32'h0000_5000;
        for (int g = 0; g < 6; g++) begin
            cyc();
            if (g == 4) begin
                chk($sformatf("starve_g%0d_addr", g), LW'(pmem_address_c), LW'(32'h0000_5000));
                resp_on(dat_c);
                chk($sformatf("starve_g%0d_resp", g), LW'({d_pmem_resp, i_pmem_resp}), LW'(2'b01));
            end else begin
                chk($sformatf("starve_g%0d_addr", g), LW'(pmem_address_c), LW'(32'h0000_4000));
                resp_on(dat_d);
                chk($sformatf("starve_g%0d_resp", g), LW'({d_pmem_resp, i_pmem_resp}), LW'(2'b10));
            end
            cyc();
            pmem_resp_c = 0;
            if (g == 5) begin
                d_pmem_read = 0;
                i_pmem_read = 0;
            end
        end
        cyc();
        chk("starve_done_idle", LW'({pmem_read_c, pmem_write_c}), '0);

        // Prefetch alone
        p_pmem_read = 1; p_pmem_address = 32'h0000_3020;
        cyc();
        chk("p_read_c", LW'(pmem_read_c), LW'(1));
        chk("p_addr", LW'(pmem_address_c), LW'(32'h0000_3020));
        resp_on(dat_e);
        chk("p_resp", LW'({p_pmem_resp, i_pmem_resp, d_pmem_resp}), LW'(3'b100));
        chk("p_rdata", p_pmem_rdata, dat_e);
        chk("p_i_rdata_hold", i_pmem_rdata, dat_c);
        p_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;

        // Prefetch with icache: i first, p after bubble
        p_pmem_read = 1; i_pmem_read = 1; i_pmem_address = 32'h0000_6000;
        cyc();
        chk("pi_i_first", LW'(pmem_address_c), LW'(32'h0000_6000));
        resp_on(dat_a);
        chk("pi_i_resp", LW'({i_pmem_resp, p_pmem_resp}), LW'(2'b10));
        i_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;
        cyc();
        chk("pi_p_after", LW'(pmem_address_c), LW'(32'h0000_3020));
        resp_on(dat_b);
        chk("pi_p_resp", LW'(p_pmem_resp), LW'(1));
        cyc();
        pmem_resp_c = 0;

        // Prefetch dropped before grant is never issued
        d_pmem_read = 1; d_pmem_address = 32'h0000_7700;
        cyc();
        chk("pd_d_first", LW'(pmem_address_c), LW'(32'h0000_7700));
        p_pmem_read = 0;
        resp_on(dat_c);
        d_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;
        cyc(); cyc();
        chk("pd_p_never", LW'({pmem_read_c, pmem_write_c, p_pmem_resp}), '0);
        chk("pd_addr_kept", LW'(pmem_address_c), LW'(32'h0000_7700));

        // Reset two cycles into a d read
        d_pmem_read = 1; d_pmem_address = 32'h0000_7000;
        cyc(); cyc();
        chk("rm_active", LW'(pmem_read_c), LW'(1));
        rst = 1;
        cyc();
        chk("rm_read_c", LW'(pmem_read_c), '0);
        resp_on(dat_d);
        chk("rm_no_d_resp", LW'(d_pmem_resp), '0);
        chk("rm_d_rdata", d_pmem_rdata, '0);
        pmem_resp_c = 0;
        rst = 0; d_pmem_read = 0;
        i_pmem_read = 1; i_pmem_address = 32'h0000_8000;
        cyc();
        chk("rm_i_grant", LW'({pmem_read_c, pmem_address_c}), LW'({1'b1, 32'h0000_8000}));
        cyc();
        resp_on(dat_e);
        chk("rm_i_resp", LW'(i_pmem_resp), LW'(1));
        chk("rm_i_rdata", i_pmem_rdata, dat_e);
        i_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;

        // d read and write together at 0x100: write, bubble, then read
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h0000_0100; d_pmem_wdata = wdat;
        cyc();
        chk("rw_write_first", LW'({pmem_read_c, pmem_write_c}), LW'(2'b01));
        resp_on(dat_a);
        chk("rw_w_resp", LW'(d_pmem_resp), LW'(1));
        d_pmem_write = 0;
        cyc();
        pmem_resp_c = 0;
        chk("rw_bubble", LW'({pmem_read_c, pmem_write_c}), '0);
        cyc();
        chk("rw_read", LW'({pmem_read_c, pmem_write_c, pmem_address_c}), LW'({2'b10, 32'h0000_0100}));
        resp_on(dat_f);
        chk("rw_r_rdata", d_pmem_rdata, dat_f);
        d_pmem_read = 0;
        cyc();
        pmem_resp_c = 0;
        chk("rw_rdata_hold", d_pmem_rdata, dat_f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_scheduler.md
PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

Interface
REQ-001 Parameter s_offset, default 5: log2 of the cacheline size in bytes; line width LW = 2**s_offset*8 bits.
REQ-002 Parameter starve_limit, default 4: maximum consecutive dcache grants while icache waits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 i_pmem_read  input  1  icache line-fill request; i_pmem_address input 32  line address.
REQ-006 i_pmem_rdata  output  LW  fill data; i_pmem_resp output 1  icache completion pulse.
REQ-007 d_pmem_read, d_pmem_write  input  1 each  dcache fill and writeback requests; d_pmem_address input 32; d_pmem_wdata input LW.
REQ-008 d_pmem_rdata  output  LW; d_pmem_resp output 1  dcache completion pulse.
REQ-009 p_pmem_read  input  1  next-line prefetch request; p_pmem_address input 32; p_pmem_rdata output LW; p_pmem_resp output 1.
REQ-010 pmem_read_c, pmem_write_c  output  1 each; pmem_address_c output 32; pmem_wdata_c output LW: command to the cacheline adaptor.
REQ-011 pmem_rdata_c  input  LW; pmem_resp_c input 1: adaptor response.

Function
REQ-012 FSM states: IDLE, SERVE_D, SERVE_I, SERVE_P; exactly one transaction outstanding at any time.
REQ-013 IDLE grant priority: dcache > icache > prefetch, except a waiting icache wins once starve_cnt == starve_limit.
REQ-014 Prefetch is granted only in a cycle where neither i_pmem_read nor d_pmem_read/d_pmem_write is asserted.
REQ-015 At grant, the winner's address, wdata and read/write type are latched into internal registers; later requester input changes do not affect the transaction.
REQ-016 Command outputs are driven from registers: a request sampled in IDLE at edge N puts the command on pmem_*_c from cycle N+1 until the cycle pmem_resp_c is sampled high.
REQ-017 With d_pmem_read and d_pmem_write both high, write is issued; the read is served by a later grant.
REQ-018 In the cycle pmem_resp_c is high, the granted requester's *_resp is high (combinational) and its *_rdata equals pmem_rdata_c; all other *_resp are 0.
REQ-019 *_rdata of non-granted requesters hold their last value; they are never X after reset (reset 0).
REQ-020 After a response, the FSM returns to IDLE for one cycle (one bubble) before the next grant.
REQ-021 starve_cnt (width clog2(starve_limit+1)) increments on each dcache grant while i_pmem_read is high; clears on any icache grant or when i_pmem_read is low in IDLE; saturates at starve_limit.
REQ-022 A requester dropping its request mid-service does not abort: the transaction completes and *_resp still pulses once.
REQ-023 A prefetch request dropped before grant is never issued.
REQ-024 pmem_resp_c high while in IDLE is ignored.

Reset
REQ-025 On rst: state IDLE; starve_cnt 0; pmem_read_c, pmem_write_c 0; pmem_address_c, pmem_wdata_c 0; all *_resp 0; all *_rdata 0.
REQ-026 Reset mid-transaction abandons it with no *_resp; the cacheline adaptor is reset by the same rst in the same cycle.
REQ-027 First grant possible at the first edge after rst deasserts.

Structure
REQ-028 The state enum pmem_sched_state_t belongs in rv32i_types; LW is derived locally from s_offset.
REQ-029 Single module; no sub-module, the priority/starvation select being under 20 lines.
REQ-030 Instantiated in mp4 in place of the existing two-port arbiter, with the prefetch port tied off when the prefetcher is absent.

Verification
REQ-031 Single icache read 0x0000_1000, adaptor resp after 5 cycles -> pmem_read_c high cycles 1-6, i_pmem_resp one pulse, i_pmem_rdata = pmem_rdata_c.
REQ-032 d write 0x8000_0040 and i read 0x0000_2000 in the same cycle -> write issued first; i served after one bubble.
REQ-033 d requests back-to-back while i held high, starve_limit=4 -> grant sequence D,D,D,D,I,D.
REQ-034 p read 0x0000_3020 alone -> granted; p read plus i read in the same cycle -> i granted, p waits; p dropped before grant -> never issued.
REQ-035 rst asserted 2 cycles into a d read -> next cycle pmem_read_c 0, no d_pmem_resp, state IDLE; a new i read then completes normally.
REQ-036 d_pmem_read and d_pmem_write both high, address 0x100 -> pmem_write_c first; after resp and bubble, pmem_read_c to 0x100.
